// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock, with
// saturation to 9999 and an overflow flag when the captured value exceeds MAX_VAL.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W   = 14,
    parameter int unsigned MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             valid,
    output logic [3:0]       thousands,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             ovf
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [3:0] LastCnt = 4'(BIN_W - 1);

    logic [1:0]       state_q, state_d;
    logic [BIN_W-1:0] shift_q, shift_d;
    logic [BIN_W-1:0] held_q, held_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [15:0]      dig_q, dig_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [15:0]      adj;

    always_comb begin
        // Per-nibble add-3 correction; no carry crosses a nibble boundary.
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end

        state_d = state_q;
        shift_d = shift_q;
        held_d  = held_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d = bin_in;
                    held_d  = bin_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                {bcd_d, shift_d} = {adj, shift_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (32'(held_q) > MAX_VAL) begin
                    dig_d = 16'h9999;
                    ovf_d = 1'b1;
                end else begin
                    dig_d = bcd_q;
                    ovf_d = 1'b0;
                end
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            held_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            held_q  <= held_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign valid     = valid_q;
    assign thousands = dig_q[15:12];
    assign hundreds  = dig_q[11:8];
    assign tens      = dig_q[7:4];
    assign ones      = dig_q[3:0];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes decimal expectations,
// a negedge monitor pops them on valid and also tracks busy/valid timing.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] bin_in = '0;
    logic        busy, valid, ovf;
    logic [3:0]  thousands, hundreds, tens, ones;

    bin_to_bcd_seq #(
        .BIN_W  (14),
        .MAX_VAL(9999)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .valid    (valid),
        .thousands(thousands),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] dig;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   last_k = -100;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain decimal arithmetic on the saturated value.
    function automatic exp_t model(input int v, input int k);
        exp_t e;
        int   s;
        s = (v > 9999) ? 9999 : v;
        e.cyc = k + 15;
        e.dig = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
        e.ovf = (v > 9999);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic exp_busy;
        exp_t e;
        exp_busy = (cyc >= last_k) && (cyc <= last_k + 14);
        checks++;
        if (busy !== exp_busy) begin
            errors++;
            $display("FAIL busy at cyc %0d: got %b expected %b", cyc, busy, exp_busy);
        end
        if (valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid at cyc %0d: got valid=1 expected 0", cyc);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc || {thousands, hundreds, tens, ones} !== e.dig || ovf !== e.ovf)
                begin
                    errors++;
                    $display("FAIL result: got cyc=%0d digits=%h ovf=%b expected cyc=%0d digits=%h ovf=%b",
                             cyc, {thousands, hundreds, tens, ones}, ovf, e.cyc, e.dig, e.ovf);
                end
            end
        end else if (q.size() > 0 && cyc >= q[0].cyc) begin
            checks++;
            errors++;
            e = q.pop_front();
            $display("FAIL missing_valid: got none at cyc %0d expected at cyc %0d", cyc, e.cyc);
        end
    end

    // mode 0: quiet, 1: random start/bin_in noise, 2: start held high, 3: scripted poke
    task automatic convert(input int v, input int mode);
        int k;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'(v);
        @(posedge clk);
        #1;
        k = cyc;
        last_k = k;
        q.push_back(model(v, k));
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            case (mode)
                1: begin start = 1'($urandom_range(0, 1)); bin_in = 14'($urandom); end
                2: start = 1'b1;
                3: begin
                    start = (i == 5);
                    if (i == 3) bin_in = 14'($urandom);
                    if (i == 5) bin_in = 14'd99;
                end
                default: start = 1'b0;
            endcase
            @(posedge clk);
        end
        #1;
        start = 1'b0;
    endtask

    initial begin
        int vals[7] = '{0, 1234, 9999, 8191, 10000, 16383, 42};
        fork
            begin
                #200000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "timeout");
            end
        join_none

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_digits", 32'({thousands, hundreds, tens, ones}), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst_n = 1'b1;

        foreach (vals[i]) convert(vals[i], (i >= 4) ? 1 : 0);
        convert(57, 3);
        repeat (2) convert(305, 2);
        convert(305, 0);

        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            convert(int'($urandom_range(0, 16383)), int'($urandom_range(0, 1)));
        end

        // Abort mid-conversion with an asynchronous reset.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd1000;
        @(posedge clk);
        #1;
        last_k = cyc;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        last_k = -100;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(valid), 0);
        chk("abort_digits", 32'({thousands, hundreds, tens, ones}), 0);
        chk("abort_ovf", 32'(ovf), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_digits_hold", 32'({thousands, hundreds, tens, ones}), 0);
        convert(777, 0);

        repeat (20) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 14, binary input width; fixed at 14 for this release.
REQ-002 SHALL have parameter MAX_VAL, default 9999, largest value shown without overflow.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  conversion request; sampled only in IDLE.
REQ-006 SHALL have port bin_in  input  14  unsigned binary value; captured on the accepting edge.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress (SHIFT or DONE).
REQ-008 SHALL have port valid  output  1  one-cycle pulse marking updated digit outputs.
REQ-009 SHALL have port thousands  output  4  BCD digit 3.
REQ-010 SHALL have port hundreds  output  4  BCD digit 2.
REQ-011 SHALL have port tens  output  4  BCD digit 1.
REQ-012 SHALL have port ones  output  4  BCD digit 0; this digit and tens feed the seven-segment serial driver's 4-bit digit inputs.
REQ-013 SHALL have port ovf  output  1  high when the last captured value exceeded MAX_VAL.

Function
REQ-014 SHALL implement the FSM states IDLE, SHIFT and DONE, with no other reachable states.
REQ-015 In IDLE with start=1 at edge k, SHALL capture bin_in into a shift register and a held copy, clear a 16-bit BCD scratch and the 4-bit iteration counter, and enter SHIFT.
REQ-016 In IDLE with start=0, SHALL remain in IDLE with outputs unchanged.
REQ-017 In SHIFT, each edge SHALL first add 3 to every scratch nibble that is >=5, then shift {scratch, shift register} left by one bit, so the MSB of the shift register enters scratch bit 0.
REQ-018 SHALL increment the iteration counter on every SHIFT edge and leave SHIFT for DONE on the 14th shift (edge k+14).
REQ-019 In DONE (edge k+15), if the held copy is <=MAX_VAL, SHALL load thousands/hundreds/tens/ones from scratch[15:12]/[11:8]/[7:4]/[3:0] and clear ovf.
REQ-020 In DONE, if the held copy is >MAX_VAL, SHALL load 9,9,9,9 into the digit outputs and set ovf=1 (saturation).
REQ-021 In DONE, SHALL assert valid for exactly the one cycle following edge k+15 and return to IDLE.
REQ-022 The total latency from the start-sampling edge to valid high SHALL be 15 clocks.
REQ-023 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE, including during the valid cycle.
REQ-024 SHALL ignore start while busy=1 and never queue it.
REQ-025 SHALL accept a start asserted during the valid cycle, giving back-to-back conversions every 16 clocks.
REQ-026 SHALL ignore changes on bin_in after capture for the remainder of that conversion.
REQ-027 The digit outputs and ovf SHALL hold their last values until the next DONE.
REQ-028 The add-3 step SHALL operate on 4-bit nibbles without carry between nibbles; no nibble SHALL exceed 9 after any shift when the value is <=9999.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force state=IDLE, busy=0, valid=0, ovf=0, all digits=0, and clear scratch and counter.
REQ-030 A reset during SHIFT or DONE SHALL abort the conversion with no valid pulse and no digit update.
REQ-031 After rst_n deasserts, SHALL accept start on the first rising edge.

Verification
REQ-032 Reset, then bin_in=0 with start pulsed at edge k -> valid at k+15; digits 0,0,0,0; ovf=0; busy high for cycles k+1..k+15.
REQ-033 bin_in=1234 -> 1,2,3,4 with ovf=0; bin_in=9999 -> 9,9,9,9 with ovf=0; bin_in=8191 -> 8,1,9,1.
REQ-034 bin_in=10000 -> 9,9,9,9 with ovf=1; then bin_in=16383 -> 9,9,9,9 with ovf=1; then bin_in=42 -> 0,0,4,2 with ovf=0.
REQ-035 Convert 57; pulse start with bin_in=99 at k+5 and change bin_in at k+3 -> only one valid, at k+15, showing 0,0,5,7.
REQ-036 Hold start=1 continuously with bin_in=305 -> valid every 16 cycles showing 0,3,0,5; busy=0 only on valid cycles.
REQ-037 Apply rst_n=0 at k+7 mid-conversion -> no valid, and digits remain 0; a fresh start with 777 then gives 0,7,7,7 15 cycles later.
